fancytimer_cmd_tx: RTL and testbench
====================================

# fancytimer_cmd_tx

Command transmitter that drives the serial `data` line of the fancy-timer receiver and closes its `done`/`ack` handshake. Per accepted request it sends the start pattern 1101, then the 4-bit delay MSB first. It waits for the timer's `done`, pulses `ack`, and reports a measured completion time or a watchdog timeout. It sits between the host-side command interface and the timer block.

## Interface
- `TICKS`, default 1000: timer cycles per delay unit. Must match the timer.
- `SLACK`, default 8: extra cycles allowed before the watchdog declares a timeout.
- `CNT_W`, default 15: watchdog/result width. Requires 16*TICKS+SLACK < 2^CNT_W; elaboration error otherwise.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: reset is asynchronous and active-high.
- `req_valid`  in  1: command offered.
- `req_ready`  out  1: transmitter can accept a command.
- `req_delay`  in  4: delay code d; timer runs (d+1)*TICKS cycles.
- `data`  out  1: serial line to the timer. Registered; 0 when not transmitting.
- `done`  in  1: timer finished, waiting for ack.
- `ack`  out  1: one-cycle acknowledge to the timer. Registered.
- `busy`  out  1: high in every state except IDLE.
- `resp_valid`  out  1: one-cycle result pulse.
- `resp_timeout`  out  1: qualifies `resp_valid`; 1 = watchdog expired.
- `resp_cycles`  out  CNT_W: WAIT_DONE cycles counted. Held until the next `resp_valid`.

## Operation
- Reset values: `data`=0, `ack`=0, `resp_valid`=0, `resp_timeout`=0, `resp_cycles`=0, `busy`=0. State is IDLE; shift register and watchdog are 0.
- States: IDLE, SEND, WAIT_DONE, ACK.
- IDLE:
  - `req_ready` = !`done`.
  - On `req_valid`&&`req_ready`, load the 8-bit shift register with {4'b1101, req_delay} and go to SEND.
  - If `done`=1 in IDLE (a stray completion after a timeout), go to ACK without a response. `req_ready` is 0 that cycle.
- SEND: 8 cycles, `data` = shift register MSB, shift left each cycle. After the 8th bit go to WAIT_DONE, clear the watchdog, and drive `data`=0.
- WAIT_DONE:
  - Watchdog increments every cycle.
  - `done`=1: go to ACK, set `resp_cycles` = watchdog+1, and pulse `resp_valid` with `resp_timeout`=0.
  - Watchdog+1 == limit with `done`=0: go to IDLE, pulse `resp_valid` with `resp_timeout`=1 and `resp_cycles`=limit.
  - If `done` and the limit coincide, `done` wins.
- Limit = (d+1)*TICKS + SLACK. Computed once at acceptance, unsigned, CNT_W bits; no wrap is possible given the parameter check.
- ACK: `ack`=1 for exactly one cycle, then go to IDLE. `ack` is never held more than one cycle and never asserted outside ACK.
- `req_delay` is sampled only at acceptance; later changes are ignored.
- Reset mid-operation: all outputs return to their reset values immediately. Any in-flight frame is abandoned; `data`=0 guarantees the timer's pattern detector sees no spurious 1s.

## Timing
- Acceptance edge E0; `data` carries 1,1,0,1,d3,d2,d1,d0 in cycles C1..C8.
- The timer's pattern bits land in C1–C4 and its shift cycles B0–B3 align with C5–C8. Its Count phase starts at C9, which is the first WAIT_DONE cycle.
- With a conforming timer, `done` first rises in cycle C9+(d+1)*TICKS. `resp_valid` is in the next cycle, together with `ack`, and `resp_cycles`=(d+1)*TICKS+1.
- IDLE re-entered the cycle after ACK. A new command can be accepted that cycle if `done` has dropped, so its first `data` bit follows one cycle later.
- Minimum back-to-back period: 8 + (d+1)*TICKS + 3 cycles.

## Structure
- Shared package `fancytimer_pkg`: the state enum, `PREAMBLE` = 4'b1101, `FRAME_BITS` = 8, and the default `TICKS`. The timer receiver also imports it.
- One sub-module: `fancytimer_wdog`, a loadable limit comparator and CNT_W up-counter with clear, enable and `expired` outputs. The FSM, shifter and handshake stay in the top.

## Test plan
- d=0, TICKS=1000, conforming timer model → `data` = 1,1,0,1,0,0,0,0 in C1..C8; `resp_valid` with `resp_timeout`=0, `resp_cycles`=1001; `ack` pulse in C1010; `busy` low in C1011.
- d=15 → frame 1,1,0,1,1,1,1,1; `resp_cycles`=16001; no timeout.
- d=2, `done` tied 0 → `resp_valid`, `resp_timeout`=1, `resp_cycles`=3008 after 3008 WAIT_DONE cycles; `ack` never asserted; `data` stays 0.
- After that timeout, raise `done` in IDLE with `req_valid`=1 → `req_ready`=0, one `ack` pulse, no `resp_valid`. The command is accepted once `done` falls.
- Assert `reset` in SEND cycle C4 → `data`, `ack`, `busy` go to 0 immediately. Next command after release produces a clean full frame.
- `done` rises on the same cycle the watchdog reaches its limit (SLACK=0, early-timeout model) → `resp_timeout`=0, `ack` pulsed.

Source files
------------

// File: rtl/fancytimer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : fancytimer_pkg                                             |
// | Purpose : Items shared by the fancy-timer command transmitter and    |
// |           the timer receiver: FSM state encoding, frame constants,   |
// |           the default tick count and the watchdog limit helper.      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package fancytimer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ACK       = 2'd3
  } state_e;

  localparam logic [3:0] PREAMBLE      = 4'b1101;
  localparam int         FRAME_BITS    = 8;
  localparam int         DEFAULT_TICKS = 1000;

  // Watchdog limit for delay code d: (d+1)*ticks + slack.
  function automatic int unsigned frame_limit(input logic [3:0]  d,
                                              input int unsigned ticks,
                                              input int unsigned slack);
    return (32'(d) + 32'd1) * ticks + slack;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fancytimer_cmd_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : fancytimer_cmd_tx_if                                     |
// | Purpose   : Host command/response handshake plus the serial link to  |
// |             the timer (data, done, ack) and the busy flag.           |
// | Modports  : master - the transmitter (drives req_ready, data, ack,   |
// |                      busy, resp_*)                                   |
// |             slave  - host + timer side (drives req_valid, req_delay, |
// |                      done)                                           |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface fancytimer_cmd_tx_if #(
  parameter int CNT_W = 15
);
  import fancytimer_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_delay;
  logic             data;
  logic             done;
  logic             ack;
  logic             busy;
  logic             resp_valid;
  logic             resp_timeout;
  logic [CNT_W-1:0] resp_cycles;

  modport master (
    input  req_valid, req_delay, done,
    output req_ready, data, ack, busy, resp_valid, resp_timeout, resp_cycles
  );

  modport slave (
    output req_valid, req_delay, done,
    input  req_ready, data, ack, busy, resp_valid, resp_timeout, resp_cycles
  );

endinterface
`default_nettype wire

// File: rtl/fancytimer_wdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fancytimer_wdog                                            |
// | Purpose : Loadable-limit watchdog. CNT_W up-counter with clear and   |
// |           enable; flags when the next count would reach the limit.   |
// | Ports   : clk, reset (async, active-high)                            |
// |           load_i/limit_i - capture a new limit                       |
// |           clr_i/en_i     - clear (priority) / increment the counter  |
// |           inc_o          - count + 1                                 |
// |           expired_o      - count + 1 == limit                        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fancytimer_wdog #(
  parameter int CNT_W = 15
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load_i,
  input  wire logic [CNT_W-1:0] limit_i,
  input  wire logic             clr_i,
  input  wire logic             en_i,
  output logic      [CNT_W-1:0] inc_o,
  output logic                  expired_o
);
  import fancytimer_pkg::*;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] w_inc;

  assign w_inc     = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign inc_o     = w_inc;
  assign expired_o = (w_inc == limit_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      limit_q <= '0;
    end else begin
      if (load_i) limit_q <= limit_i;
      if (clr_i)     count_q <= '0;
      else if (en_i) count_q <= w_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fancytimer_cmd_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fancytimer_cmd_tx                                          |
// | Purpose : Sends {1101, delay[3:0]} MSB first to the fancy timer,     |
// |           waits for done, acks it and reports the measured cycle     |
// |           count or a watchdog timeout.                               |
// | Ports   : clk, reset (async, active-high)                            |
// |           bus (master) - req_valid/req_ready/req_delay, data, done,  |
// |                          ack, busy, resp_valid/resp_timeout/         |
// |                          resp_cycles                                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fancytimer_cmd_tx #(
  parameter int TICKS = fancytimer_pkg::DEFAULT_TICKS,
  parameter int SLACK = 8,
  parameter int CNT_W = 15
) (
  input  wire logic           clk,
  input  wire logic           reset,
  fancytimer_cmd_tx_if.master bus
);
  import fancytimer_pkg::*;

  // The longest limit must fit the watchdog without wrapping.
  if ((64'(16) * 64'(TICKS) + 64'(SLACK)) >= (64'(1) << CNT_W)) begin : g_param_check
    $error("fancytimer_cmd_tx: 16*TICKS+SLACK must be below 2**CNT_W");
  end

  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);

  state_e           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic             data_q, data_d;
  logic             ack_q, ack_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_timeout_q, resp_timeout_d;
  logic [CNT_W-1:0] resp_cycles_q, resp_cycles_d;

  logic             w_req_ready;
  logic             w_wd_load, w_wd_clr, w_wd_en;
  logic             w_wd_expired;
  logic [CNT_W-1:0] w_wd_inc;
  logic [CNT_W-1:0] w_limit;

  assign w_limit = CNT_W'(frame_limit(bus.req_delay, TICKS, SLACK));

  fancytimer_wdog #(.CNT_W(CNT_W)) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .load_i    (w_wd_load),
    .limit_i   (w_limit),
    .clr_i     (w_wd_clr),
    .en_i      (w_wd_en),
    .inc_o     (w_wd_inc),
    .expired_o (w_wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      shreg_q        <= '0;
      bitcnt_q       <= '0;
      data_q         <= 1'b0;
      ack_q          <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_cycles_q  <= '0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bitcnt_q       <= bitcnt_d;
      data_q         <= data_d;
      ack_q          <= ack_d;
      resp_valid_q   <= resp_valid_d;
      resp_timeout_q <= resp_timeout_d;
      resp_cycles_q  <= resp_cycles_d;
    end
  end

  // data/ack/resp are registered, so their next values are decided on
  // the transition into the state in which they must be visible.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    bitcnt_d       = bitcnt_q;
    data_d         = 1'b0;
    ack_d          = 1'b0;
    resp_valid_d   = 1'b0;
    resp_timeout_d = resp_timeout_q;
    resp_cycles_d  = resp_cycles_q;
    w_wd_load      = 1'b0;
    w_wd_clr       = 1'b0;
    w_wd_en        = 1'b0;
    w_req_ready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        w_req_ready = !bus.done;
        if (bus.done) begin
          // Late completion after a timeout: ack it silently.
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end else if (bus.req_valid) begin
          shreg_d   = {PREAMBLE, bus.req_delay};
          bitcnt_d  = '0;
          data_d    = shreg_d[7];
          w_wd_load = 1'b1;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        // Rotate rather than shift: same MSB sequence, no dead bit.
        shreg_d  = {shreg_q[6:0], shreg_q[7]};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == LAST_BIT) begin
          w_wd_clr = 1'b1;
          state_d  = ST_WAIT_DONE;
        end else begin
          data_d = shreg_q[6];
        end
      end

      ST_WAIT_DONE: begin
        w_wd_en = 1'b1;
        if (bus.done) begin
          // done takes priority over a simultaneous watchdog expiry.
          state_d        = ST_ACK;
          ack_d          = 1'b1;
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b0;
          resp_cycles_d  = w_wd_inc;
        end else if (w_wd_expired) begin
          state_d        = ST_IDLE;
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
          resp_cycles_d  = w_wd_inc;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.data         = data_q;
  assign bus.ack          = ack_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_timeout = resp_timeout_q;
  assign bus.resp_cycles  = resp_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_fancytimer_cmd_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fancytimer_cmd_tx                                       |
// | Purpose : Self-checking bench for fancytimer_cmd_tx: directed table  |
// |           of transactions, random transactions against a reference  |
// |           model, stray-done and mid-frame reset sequences.           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_fancytimer_cmd_tx;

  localparam int TICKS = 1000;
  localparam int SLACK = 8;
  localparam int CNT_W = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fancytimer_cmd_tx_if #(.CNT_W(CNT_W)) bus ();

  fancytimer_cmd_tx #(
    .TICKS (TICKS),
    .SLACK (SLACK),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] d;
    int         k;        // WAIT_DONE cycle index where done rises, -1 = never
    bit         exp_to;
    int         exp_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: done raised in WAIT_DONE cycle k ends the wait after k+1
  // cycles unless the limit (d+1)*TICKS+SLACK arrives first.
  function automatic int model_limit(input int d);
    return (d + 1) * TICKS + SLACK;
  endfunction

  function automatic bit model_timeout(input int d, input int k);
    return (k < 0) || (k + 1 > model_limit(d));
  endfunction

  function automatic int model_cycles(input int d, input int k);
    return model_timeout(d, k) ? model_limit(d) : k + 1;
  endfunction

  // Entered and left at a negedge with the DUT idle and done low.
  task automatic run_txn(input logic [3:0] d, input int k, input bit exp_to,
                         input int exp_cyc, input string tag);
    logic [7:0] frame;
    logic [7:0] exp_frame;
    bit         bad_busy;
    bit         bad_wait;
    bit         got;
    int         w;
    exp_frame = {4'b1101, d};
    bad_busy  = 1'b0;
    bad_wait  = 1'b0;
    got       = 1'b0;
    w         = 0;

    bus.req_valid = 1'b1;
    bus.req_delay = d;
    #1;
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_delay = 4'($urandom);
    for (int i = 0; i < 8; i++) begin
      frame[7-i] = bus.data;
      if (bus.busy !== 1'b1) bad_busy = 1'b1;
      if (i < 7) tick();
    end
    check({tag, " frame"}, 32'(frame), 32'(exp_frame));
    check({tag, " busy_send"}, 32'(bad_busy), 32'd0);
    tick();

    while (!got && w < 20000) begin
      if (w == k) bus.done = 1'b1;
      if (bus.data !== 1'b0 || bus.ack !== 1'b0 || bus.resp_valid !== 1'b0 || bus.busy !== 1'b1)
        bad_wait = 1'b1;
      tick();
      w++;
      if (bus.resp_valid === 1'b1) got = 1'b1;
    end
    check({tag, " resp_seen"}, 32'(got), 32'd1);
    check({tag, " wait_quiet"}, 32'(bad_wait), 32'd0);
    check({tag, " wait_len"}, 32'(w), 32'(exp_cyc));
    check({tag, " resp_timeout"}, 32'(bus.resp_timeout), 32'(exp_to));
    check({tag, " resp_cycles"}, 32'(bus.resp_cycles), 32'(exp_cyc));
    check({tag, " ack"}, 32'(bus.ack), 32'(!exp_to));
    check({tag, " busy_resp"}, 32'(bus.busy), 32'(!exp_to));
    bus.done = 1'b0;
    tick();
    check({tag, " ack_after"}, 32'(bus.ack), 32'd0);
    check({tag, " rv_after"}, 32'(bus.resp_valid), 32'd0);
    check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, " cycles_held"}, 32'(bus.resp_cycles), 32'(exp_cyc));
  endtask

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL global_timeout: simulation still running, expected to finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "bench time limit");
  end

  initial begin
    int d_r;
    int k_r;
    int mode;
    int lim;

    vecs[0] = '{d: 4'd0,  k: 1000,  exp_to: 1'b0, exp_cyc: 1001};
    vecs[1] = '{d: 4'd15, k: 16000, exp_to: 1'b0, exp_cyc: 16001};
    vecs[2] = '{d: 4'd0,  k: 1007,  exp_to: 1'b0, exp_cyc: 1008};  // done meets limit
    vecs[3] = '{d: 4'd3,  k: 5,     exp_to: 1'b0, exp_cyc: 6};
    vecs[4] = '{d: 4'd1,  k: 2008,  exp_to: 1'b1, exp_cyc: 2008};  // one cycle too late
    vecs[5] = '{d: 4'd2,  k: -1,    exp_to: 1'b1, exp_cyc: 3008};

    bus.req_valid = 1'b0;
    bus.req_delay = 4'd0;
    bus.done      = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst data", 32'(bus.data), 32'd0);
    check("rst ack", 32'(bus.ack), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_timeout", 32'(bus.resp_timeout), 32'd0);
    check("rst resp_cycles", 32'(bus.resp_cycles), 32'd0);
    check("rst req_ready", 32'(bus.req_ready), 32'd1);

    for (int r = 0; r < 6; r++)
      run_txn(vecs[r].d, vecs[r].k, vecs[r].exp_to, vecs[r].exp_cyc, $sformatf("row%0d", r));

    // Stray done in IDLE after the timeout: ack it, no response.
    bus.done      = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_delay = 4'd9;
    #1;
    check("stray req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check("stray ack", 32'(bus.ack), 32'd1);
    check("stray resp_valid", 32'(bus.resp_valid), 32'd0);
    bus.done = 1'b0;
    tick();
    check("stray ack_once", 32'(bus.ack), 32'd0);
    check("stray rv_after", 32'(bus.resp_valid), 32'd0);
    #1;
    check("stray ready_again", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    check("stray accepted busy", 32'(bus.busy), 32'd1);
    check("stray accepted data_c1", 32'(bus.data), 32'd1);
    repeat (3) tick();
    check("mid data_c4", 32'(bus.data), 32'd1);

    // Reset in C4: outputs clear without waiting for a clock edge.
    reset = 1'b1;
    #1;
    check("mid rst data", 32'(bus.data), 32'd0);
    check("mid rst busy", 32'(bus.busy), 32'd0);
    check("mid rst ack", 32'(bus.ack), 32'd0);
    check("mid rst resp_cycles", 32'(bus.resp_cycles), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_txn(4'd5, 6000, 1'b0, 6001, "post_rst");

    for (int r = 0; r < 6; r++) begin
      d_r  = int'($urandom_range(0, 3));
      lim  = model_limit(d_r);
      mode = int'($urandom_range(0, 3));
      case (mode)
        0:       k_r = -1;
        1:       k_r = int'($urandom_range(0, lim - 1));
        2:       k_r = lim - 1;
        default: k_r = (d_r + 1) * TICKS;
      endcase
      run_txn(4'(d_r), k_r, model_timeout(d_r, k_r), model_cycles(d_r, k_r),
              $sformatf("rnd%0d d%0d k%0d", r, d_r, k_r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
